// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// default register-index width, counter width and a saturating-increment helper.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MD_WAIT  = 2'd1,
      ST_MEM_WAIT = 2'd2
   } ctrl_state_t;

   localparam int REG_BITS_DEF = 5;
   localparam int CNT_WIDTH    = 16;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   // Increment that sticks at the all-ones value instead of wrapping.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
      logic [CNT_WIDTH-1:0] result;
      if (value == CNT_MAX) begin
         result = value;
      end else begin
         result = value + CNT_ONE;
      end
      return result;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter with increment enable and asynchronous active-low clear.
module sat_counter
   import pipe_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] count
);

   // Count enabled events, holding at the maximum once reached.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= {CNT_WIDTH{1'b0}};
      end else if (inc) begin
         count <= sat_inc(count);
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Decides every cycle
// whether PC, IF/ID, ID/EX and EX/MEM load, hold or clear to a bubble, based on
// load-use hazards, taken branches, data-memory waits and multi-cycle mul/div.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MD_LATENCY = 4,
   parameter int REG_BITS   = REG_BITS_DEF
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [REG_BITS-1:0]  id_rs,
   input  logic [REG_BITS-1:0]  id_rt,
   input  logic                 id_uses_rs,
   input  logic                 id_uses_rt,
   input  logic                 ex_mem_read,
   input  logic [REG_BITS-1:0]  ex_rd,
   input  logic                 ex_is_md,
   input  logic                 branch_taken,
   input  logic                 dmem_req,
   input  logic                 dmem_ready,
   output logic                 pc_write,
   output logic                 if_id_write,
   output logic                 if_id_flush,
   output logic                 id_ex_write,
   output logic                 id_ex_flush,
   output logic                 ex_mem_write,
   output logic                 ex_mem_flush,
   output logic [1:0]           ctrl_state,
   output logic [CNT_WIDTH-1:0] stall_cycles,
   output logic [CNT_WIDTH-1:0] flush_count
);

   // Counter reload on mul/div entry: the entry cycle counts as the first EX cycle.
   localparam logic [3:0] MD_INIT = 4'(MD_LATENCY - 1);

   ctrl_state_t state_r;
   ctrl_state_t state_nxt_s;
   logic [3:0]  md_cnt_r;
   logic [3:0]  md_cnt_nxt_s;
   logic        mem_wait_s;
   logic        load_use_s;
   logic        flush_inc_s;
   logic        stall_inc_s;

   // A waiting data-memory access freezes everything and outranks all other events.
   assign mem_wait_s = dmem_req & ~dmem_ready;

   // Load-use: the load in EX writes a register the ID instruction reads; r0 never hazards.
   assign load_use_s = ex_mem_read && (ex_rd != {REG_BITS{1'b0}}) &&
                       ((id_uses_rs && (id_rs == ex_rd)) ||
                        (id_uses_rt && (id_rt == ex_rd)));

   // Priority mux for pipeline controls plus next-state / mul-div counter logic.
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_write  = 1'b1;
      id_ex_flush  = 1'b0;
      ex_mem_write = 1'b1;
      ex_mem_flush = 1'b0;
      state_nxt_s  = state_r;
      md_cnt_nxt_s = md_cnt_r;
      flush_inc_s  = 1'b0;

      if (!rst_n) begin
         // Fill every stage with bubbles while reset is held.
         pc_write     = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         state_nxt_s  = ST_RUN;
         md_cnt_nxt_s = 4'd0;
      end else if (mem_wait_s) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         state_nxt_s  = ST_MEM_WAIT;
      end else begin
         case (state_r)
            ST_MD_WAIT: begin
               pc_write     = 1'b0;
               if_id_write  = 1'b0;
               id_ex_write  = 1'b0;
               md_cnt_nxt_s = md_cnt_r - 4'd1;
               if (md_cnt_r == 4'd1) begin
                  // Last cycle: let the result leave EX.
                  ex_mem_flush = 1'b0;
                  state_nxt_s  = ST_RUN;
               end else begin
                  ex_mem_flush = 1'b1;
               end
            end
            ST_RUN, ST_MEM_WAIT: begin
               // The memory-ready cycle behaves exactly like RUN.
               state_nxt_s = ST_RUN;
               if (branch_taken) begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
                  flush_inc_s = 1'b1;
               end else if (load_use_s) begin
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  id_ex_flush = 1'b1;
               end else begin
                  pc_write    = 1'b1;
               end
               if (ex_is_md) begin
                  state_nxt_s  = ST_MD_WAIT;
                  md_cnt_nxt_s = MD_INIT;
               end else begin
                  md_cnt_nxt_s = md_cnt_r;
               end
            end
            default: begin
               state_nxt_s = ST_RUN;
            end
         endcase
      end
   end

   // State and mul/div countdown registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_RUN;
         md_cnt_r <= 4'd0;
      end else begin
         state_r  <= state_nxt_s;
         md_cnt_r <= md_cnt_nxt_s;
      end
   end

   assign ctrl_state  = state_r;
   assign stall_inc_s = ~pc_write;

   sat_counter u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_inc_s),
      .count (stall_cycles)
   );

   sat_counter u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush_inc_s),
      .count (flush_count)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

   localparam int MD_LAT = 4;
   localparam int RB     = 5;

   logic          clk;
   logic          rst_n;
   logic [RB-1:0] id_rs, id_rt, ex_rd;
   logic          id_uses_rs, id_uses_rt, ex_mem_read, ex_is_md;
   logic          branch_taken, dmem_req, dmem_ready;
   logic          pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
   logic          ex_mem_write, ex_mem_flush;
   logic [1:0]    ctrl_state;
   logic [15:0]   stall_cycles, flush_count;

   int checks   = 0;
   int failures = 0;

   // Model state: remaining MD_WAIT cycles, memory-wait flag, counter values.
   int m_md_rem;
   bit m_memw;
   int m_stall;
   int m_flush;
   bit e_pc, e_ifw, e_iff, e_idw, e_idf, e_exw, e_exf, e_br;
   int e_state;

   pipeline_hazard_ctrl #(.MD_LATENCY(MD_LAT), .REG_BITS(RB)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_is_md(ex_is_md),
      .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
      .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
      .ex_mem_write(ex_mem_write), .ex_mem_flush(ex_mem_flush),
      .ctrl_state(ctrl_state), .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_md_rem = 0;
      m_memw   = 1'b0;
      m_stall  = 0;
      m_flush  = 0;
   endtask

   // Expected controls for the current inputs, straight from the priority rules.
   task automatic model_comb();
      bit hazard;
      e_pc = 1; e_ifw = 1; e_iff = 0; e_idw = 1; e_idf = 0; e_exw = 1; e_exf = 0; e_br = 0;
      hazard = ex_mem_read && (ex_rd != 0) &&
               ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
      if (dmem_req && !dmem_ready) begin
         e_pc = 0; e_ifw = 0; e_idw = 0; e_exw = 0;
      end else if (m_md_rem > 0) begin
         e_pc = 0; e_ifw = 0; e_idw = 0;
         e_exf = (m_md_rem > 1);
      end else if (branch_taken) begin
         e_iff = 1; e_idf = 1; e_br = 1;
      end else if (hazard) begin
         e_pc = 0; e_ifw = 0; e_idf = 1;
      end
      e_state = m_memw ? 2 : ((m_md_rem > 0) ? 1 : 0);
   endtask

   // Advance the model across one clock edge.
   task automatic model_seq();
      if (dmem_req && !dmem_ready) begin
         m_memw = 1'b1;
         m_md_rem = 0;
      end else if (m_md_rem > 0) begin
         m_md_rem--;
         m_memw = 1'b0;
      end else begin
         m_memw = 1'b0;
         if (ex_is_md) m_md_rem = MD_LAT - 1;
      end
      if (!e_pc && m_stall < 65535) m_stall++;
      if (e_br && m_flush < 65535) m_flush++;
   endtask

   // Called at a negedge with inputs set; checks mid-cycle, then crosses posedge.
   task automatic tick(input bit do_chk);
      #1;
      model_comb();
      if (do_chk) begin
         chk_val("pc_write",     pc_write,     e_pc);
         chk_val("if_id_write",  if_id_write,  e_ifw);
         chk_val("if_id_flush",  if_id_flush,  e_iff);
         chk_val("id_ex_write",  id_ex_write,  e_idw);
         chk_val("id_ex_flush",  id_ex_flush,  e_idf);
         chk_val("ex_mem_write", ex_mem_write, e_exw);
         chk_val("ex_mem_flush", ex_mem_flush, e_exf);
         chk_val("ctrl_state",   ctrl_state,   e_state);
         chk_val("stall_cycles", stall_cycles, m_stall);
         chk_val("flush_count",  flush_count,  m_flush);
      end
      @(posedge clk);
      model_seq();
      @(negedge clk);
   endtask

   task automatic chk_reset(input string tag);
      chk_val({tag, "_pc_write"},     pc_write,     1'b0);
      chk_val({tag, "_if_id_write"},  if_id_write,  1'b1);
      chk_val({tag, "_if_id_flush"},  if_id_flush,  1'b1);
      chk_val({tag, "_id_ex_write"},  id_ex_write,  1'b1);
      chk_val({tag, "_id_ex_flush"},  id_ex_flush,  1'b1);
      chk_val({tag, "_ex_mem_write"}, ex_mem_write, 1'b1);
      chk_val({tag, "_ex_mem_flush"}, ex_mem_flush, 1'b1);
      chk_val({tag, "_state"},        ctrl_state,   2'd0);
      chk_val({tag, "_stall"},        stall_cycles, 16'd0);
      chk_val({tag, "_flush"},        flush_count,  16'd0);
   endtask

   task automatic clear_inputs();
      id_rs = '0; id_rt = '0; ex_rd = '0;
      id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0; ex_is_md = 0;
      branch_taken = 0; dmem_req = 0; dmem_ready = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      #2;
      chk_reset("rst0");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Load-use on rs.
      ex_mem_read = 1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1;
      tick(1);
      chk_val("lu_stall_cnt", stall_cycles, 16'd1);
      // Register 0 never hazards.
      ex_rd = 5'd0; id_rs = 5'd0;
      tick(1);
      chk_val("r0_stall_cnt", stall_cycles, 16'd1);
      // Branch beats load-use.
      ex_rd = 5'd5; id_rs = 5'd5; branch_taken = 1;
      tick(1);
      chk_val("br_flush_cnt", flush_count, 16'd1);
      chk_val("br_stall_cnt", stall_cycles, 16'd1);
      clear_inputs();

      // Mul/div: entry cycle plus three MD_WAIT cycles.
      ex_is_md = 1;
      tick(1);
      ex_is_md = 0;
      for (int i = 0; i < MD_LAT - 1; i++) tick(1);
      tick(1);
      chk_val("md_stall_cnt", stall_cycles, 16'd4);

      // Data-memory wait with a branch that must be masked.
      dmem_req = 1; dmem_ready = 0; branch_taken = 1;
      for (int i = 0; i < 3; i++) tick(1);
      branch_taken = 0; dmem_ready = 1;
      tick(1);
      clear_inputs();
      tick(1);
      chk_val("mem_flush_cnt", flush_count, 16'd1);
      chk_val("mem_stall_cnt", stall_cycles, 16'd7);

      // Asynchronous reset in the middle of MD_WAIT.
      ex_is_md = 1;
      tick(1);
      ex_is_md = 0;
      tick(1);
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset("rst_md");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);

      // Randomized traffic over small register indices to provoke hazards.
      for (int n = 0; n < 3000; n++) begin
         id_rs        = 5'($urandom_range(0, 3));
         id_rt        = 5'($urandom_range(0, 3));
         ex_rd        = 5'($urandom_range(0, 3));
         id_uses_rs   = 1'($urandom_range(0, 1));
         id_uses_rt   = 1'($urandom_range(0, 1));
         ex_mem_read  = 1'($urandom_range(0, 1));
         ex_is_md     = ($urandom_range(0, 7) == 0);
         branch_taken = ($urandom_range(0, 3) == 0);
         dmem_req     = ($urandom_range(0, 2) == 0);
         dmem_ready   = 1'($urandom_range(0, 1));
         tick(1);
      end

      // Saturation: long freeze drives the stall counter past its limit.
      clear_inputs();
      dmem_req = 1; dmem_ready = 0;
      for (int n = 0; n < 65540; n++) tick(0);
      tick(1);
      chk_val("sat_stall_cnt", stall_cycles, 16'hFFFF);
      tick(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. Each cycle it decides whether the PC and the IF/ID, ID/EX and EX/MEM pipeline registers load, hold or are cleared to a bubble. Inputs are load-use hazards, taken branches and jumps, data-memory wait states and a fixed-latency multiply/divide unit. It drives the `Flush` and `IF_ID_Write` controls of the IF/ID register and the equivalent controls of the downstream stages.

## Interface
- `MD_LATENCY`, default 4: total EX-stage cycles of a mul/div op; legal range 2..15.
- `REG_BITS`, default 5: register-index width.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_rs`, `id_rt` in `REG_BITS`: source registers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt` in 1: the ID instruction actually reads `rs` / `rt`.
- `ex_mem_read` in 1: the EX instruction is a load.
- `ex_rd` in `REG_BITS`: destination of the EX instruction.
- `ex_is_md` in 1: the EX instruction is a mul/div.
- `branch_taken` in 1: a branch or jump resolved taken in EX this cycle.
- `dmem_req` in 1: the MEM stage is accessing data memory.
- `dmem_ready` in 1: the data-memory access completes this cycle.
- `pc_write` out 1: the PC loads its next value.
- `if_id_write` out 1: the IF/ID register loads.
- `if_id_flush` out 1: the IF/ID register clears to 0. Only acts when `if_id_write`=1.
- `id_ex_write` out 1: the ID/EX register loads.
- `id_ex_flush` out 1: the ID/EX register clears, inserting a bubble.
- `ex_mem_write` out 1: the EX/MEM register loads.
- `ex_mem_flush` out 1: the EX/MEM register clears.
- `ctrl_state` out 2: current FSM state.
- `stall_cycles` out 16: saturating count of cycles with `pc_write`=0.
- `flush_count` out 16: saturating count of taken-branch flushes.

## Operation
- **States:** RUN=0, MD_WAIT=1, MEM_WAIT=2.
- **Default (RUN, no event):** all `*_write`=1, all `*_flush`=0.
- **Load-use hazard:** `ex_mem_read` && `ex_rd`≠0 && ((`id_uses_rs` && `id_rs`==`ex_rd`) || (`id_uses_rt` && `id_rt`==`ex_rd`)).
  - Response: `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1.
  - Lasts exactly one cycle; the state is unchanged.
- **Taken branch:** `if_id_flush`=1 and `id_ex_flush`=1; the PC loads the target. The branch itself proceeds to EX/MEM.
- **Data-memory wait:** `dmem_req` && !`dmem_ready`.
  - Response: `pc_write`, `if_id_write`, `id_ex_write` and `ex_mem_write` are all 0, freezing the whole pipeline.
  - Next state is MEM_WAIT. The FSM stays there while `dmem_req` && !`dmem_ready`, and returns to RUN in the cycle `dmem_ready`=1.
  - MEM_WAIT outputs are identical to the freeze above. The ready cycle itself uses RUN outputs.
- **Mul/div:** `ex_is_md` in RUN loads `md_cnt`=`MD_LATENCY`−1 and moves to MD_WAIT.
  - MD_WAIT outputs: `pc_write`, `if_id_write` and `id_ex_write` are 0, and `ex_mem_flush`=1.
  - `md_cnt` decrements each cycle. When `md_cnt`==1, the next state is RUN and `ex_mem_write`=1, `ex_mem_flush`=0, so the result leaves EX.
- **Priority, highest first:** reset, MEM_WAIT/data-memory wait, MD_WAIT, taken branch, load-use.
  - Branch and load-use in the same cycle: the branch wins. No stall, and both IF/ID and ID/EX are flushed.
  - Mul/div entering while the data memory waits: the mul/div is deferred until the memory completes, because `ex_is_md` is still asserted then.
- **Counters:** saturate at 0xFFFF. `flush_count` increments only when a branch flush is actually applied, i.e. not masked by a freeze.
- **Width rules:** register compares are exact `REG_BITS`-wide. Register 0 never creates a hazard.

## Timing
- All hazard and stall outputs are combinational from the current state and inputs, in the same cycle as the event (0-cycle latency). The state, `md_cnt` and the counters update on `posedge clk`.
- While `rst_n`=0 (asynchronous):
  - State: RUN, `md_cnt`=0, both counters 0.
  - Outputs forced: `pc_write`=0, `if_id_write`=1, `if_id_flush`=1, `id_ex_write`=1, `id_ex_flush`=1, `ex_mem_write`=1, `ex_mem_flush`=1, so the pipeline fills with bubbles.
- Reset asserted mid-MD_WAIT or mid-MEM_WAIT aborts immediately to RUN. The first cycle after release behaves as RUN.
- A mul/div occupies EX for exactly `MD_LATENCY` cycles: the entry cycle plus `MD_LATENCY`−1 in MD_WAIT.
- `dmem_ready` arriving in the same cycle as `dmem_req` causes no stall.

## Structure
- A shared `pipe_ctrl_pkg` holds:
  - the state encoding constants RUN, MD_WAIT and MEM_WAIT;
  - the `REG_BITS` default;
  - the counter width, 16.
- One sub-module is natural: `sat_counter` (16-bit, increment-enable, saturating, async active-low clear), instantiated twice.
- The hazard compare and the priority mux stay inline.

## Test plan
- **Load-use:**
  - Stimulus: `ex_mem_read`=1, `ex_rd`=5, `id_rs`=5, `id_uses_rs`=1 for one cycle.
  - Expected: `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1 in that cycle; `stall_cycles`=1.
  - Repeat with `ex_rd`=0: no stall.
- **Branch beats load-use:**
  - Stimulus: the load-use hazard plus `branch_taken`=1.
  - Expected: `pc_write`=1, `if_id_flush`=1, `id_ex_flush`=1; `flush_count`=1; `stall_cycles` unchanged.
- **Mul/div, `MD_LATENCY`=4:**
  - Stimulus: `ex_is_md` pulse.
  - Expected: `ctrl_state`=MD_WAIT for 3 cycles with `pc_write`=0 and `ex_mem_flush`=1 on the first two; the third cycle has `ex_mem_write`=1; then RUN; `stall_cycles`=3.
- **Data-memory wait:**
  - Stimulus: `dmem_req`=1, `dmem_ready` low for 3 cycles then high.
  - Expected: all `*_write`=0 for those 3 cycles; RUN outputs on the ready cycle. A `branch_taken` during the wait causes no flush, and `flush_count` is unchanged.
- **Reset mid-MD_WAIT:**
  - Stimulus: drop `rst_n` asynchronously two cycles into MD_WAIT.
  - Expected: state RUN, counters 0, and the reset output values immediately, before the next edge.
- **Saturation:** preload via 65 540 forced stall cycles; `stall_cycles` holds at 0xFFFF.
